// File: rtl/arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter: one-hot rotate and encode.
// Vectors are carried at MAX_REQ bits so one function serves every NUM_REQ.
package arb_pkg;

  localparam int MAX_REQ        = 32;
  localparam int MAX_IDX_W      = 5;
  localparam int DEFAULT_WEIGHT = 1;

  // Rotate left by one within the low n bits; bits at and above n come back zero.
  function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] v, input int n);
    logic [MAX_REQ-1:0] mask;
    mask = (n >= MAX_REQ) ? '1 : ((MAX_REQ'(1) << n) - MAX_REQ'(1));
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = idx | i[MAX_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req at or above the one-hot base, wrapping.
// Purely combinational; all-zero out when req is zero.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] base_i,
  output logic [N-1:0] pick_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Subtracting the base clears every request bit below it in the doubled
  // vector, so the lowest survivor is the wrapped round-robin winner.
  assign dbl    = {req_i, req_i};
  assign masked = dbl & ~(dbl - {{N{1'b0}}, base_i});
  assign pick_o = masked[N-1:0] | masked[2*N-1:N];

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: winner keeps the grant for up to max(weight,1)
// accepted transfers, or indefinitely while lock_i is held; zero-cycle grant.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_i,
  input  logic                        lock_i,
  input  logic                        ready_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [IDX_W-1:0]            gnt_idx_o,
  output logic                        valid_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [NUM_REQ-1:0]  ptr_q, ptr_d;
  logic [0:0]          busy_q, busy_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [WEIGHT_W-1:0] wt [NUM_REQ];
  logic [NUM_REQ-1:0]  pick;
  logic [NUM_REQ-1:0]  cur_oh;
  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [WEIGHT_W-1:0] wt_sel;
  logic [WEIGHT_W-1:0] eff;
  logic [NUM_REQ-1:0]  ptr_after_win;
  logic [NUM_REQ-1:0]  ptr_after_cur;
  logic                own;
  logic                xfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wt
    assign wt[g] = weight_i[g*WEIGHT_W +: WEIGHT_W];
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (req_i),
    .base_i (ptr_q),
    .pick_o (pick)
  );

  assign own     = (busy_q == ST_BURST) && req_i[cur_q];
  assign cur_oh  = NUM_REQ'(1) << cur_q;
  assign gnt     = own ? cur_oh : pick;
  assign gnt_idx = IDX_W'(onehot2idx(MAX_REQ'(gnt)));
  assign xfer    = (|gnt) && ready_i;

  // A zero weight still earns one beat, otherwise the requester would starve.
  assign wt_sel = wt[gnt_idx];
  assign eff    = (wt_sel == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : wt_sel;

  assign ptr_after_win = NUM_REQ'(rotl1(MAX_REQ'(gnt), NUM_REQ));
  assign ptr_after_cur = NUM_REQ'(rotl1(MAX_REQ'(cur_oh), NUM_REQ));

  always_comb begin
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    if (xfer && !own) begin
      if (lock_i || (eff > WEIGHT_W'(1))) begin
        busy_d   = ST_BURST;
        cur_d    = gnt_idx;
        credit_d = eff - WEIGHT_W'(1);
      end else begin
        busy_d = ST_IDLE;
        ptr_d  = ptr_after_win;
      end
    end else if (xfer && own) begin
      if (!lock_i) begin
        if (credit_q <= WEIGHT_W'(1)) begin
          busy_d = ST_IDLE;
          ptr_d  = ptr_after_cur;
        end else begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
    end else if (busy_q == ST_BURST && !req_i[cur_q]) begin
      // Owner walked away mid-burst: forfeit the rest and pass priority on.
      busy_d = ST_IDLE;
      ptr_d  = ptr_after_cur;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= NUM_REQ'(1);
      busy_q   <= ST_IDLE;
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o     = gnt;
  assign gnt_idx_o = gnt_idx;
  assign valid_o   = |gnt;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed vector table plus randomized run against a behavioural model of wrr_arbiter.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*WW-1:0] wt;
  logic          lock;
  logic          ready;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .weight_i  (wt),
    .lock_i    (lock),
    .ready_i   (ready),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority start index, current owner (-1 = none), beats left.
  int m_base, m_owner, m_left;

  task automatic m_reset();
    m_base  = 0;
    m_owner = -1;
    m_left  = 0;
  endtask

  function automatic int m_pick();
    if (m_owner >= 0 && req[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_base + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_edge();
    int  g;
    int  e;
    bit  active;
    g = m_pick();
    active = (m_owner >= 0) && req[m_owner];
    if (g >= 0 && ready) begin
      if (!active) begin
        e = int'((wt >> (g * WW)) & 16'hF);
        if (e == 0) e = 1;
        if (lock || e > 1) begin
          m_owner = g;
          m_left  = e - 1;
        end else begin
          m_owner = -1;
          m_base  = (g + 1) % N;
        end
      end else if (!lock) begin
        if (m_left <= 1) begin
          m_base  = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_left--;
        end
      end
    end else if (m_owner >= 0 && !req[m_owner]) begin
      m_base  = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    bit           lock;
    bit           ready;
    logic [15:0]  wt;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [N-1:0] rq, input bit lk, input bit rd,
                     input logic [15:0] w, input logic [N-1:0] ex, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.ready = rd; v.wt = w; v.exp = ex; v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; wt = '0; lock = 1'b0; ready = 1'b0;
    m_reset();

    // Equal weights rotate one beat each.
    add(1, 4'h0, 0, 1, 16'h1111, 4'h0, "t1_reset");
    add(0, 4'h0, 0, 1, 16'h1111, 4'h0, "t1_noreq");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h1, "t1_c0");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h2, "t1_c1");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h4, "t1_c2");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h8, "t1_c3");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h1, "t1_c4");
    // Requester 3 gets a three-beat burst.
    add(1, 4'h0, 0, 1, 16'h3111, 4'h0, "t2_reset");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h1, "t2_c0");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h2, "t2_c1");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h4, "t2_c2");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h8, "t2_c3");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h8, "t2_c4");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h8, "t2_c5");
    add(0, 4'hF, 0, 1, 16'h3111, 4'h1, "t2_c6");
    // Backpressure holds the grant; the pointer lands on requester 1 afterwards.
    add(1, 4'h0, 0, 0, 16'h0002, 4'h0, "t3_reset");
    add(0, 4'h1, 0, 0, 16'h0002, 4'h1, "t3_stall0");
    add(0, 4'h1, 0, 0, 16'h0002, 4'h1, "t3_stall1");
    add(0, 4'h1, 0, 0, 16'h0002, 4'h1, "t3_stall2");
    add(0, 4'h1, 0, 1, 16'h0002, 4'h1, "t3_xfer0");
    add(0, 4'h1, 0, 1, 16'h0002, 4'h1, "t3_xfer1");
    add(0, 4'h3, 0, 0, 16'h0002, 4'h2, "t3_ptr");
    // Owner drops its request mid-burst.
    add(1, 4'h0, 0, 1, 16'h0024, 4'h0, "t4_reset");
    add(0, 4'h3, 0, 1, 16'h0024, 4'h1, "t4_start");
    add(0, 4'h2, 0, 1, 16'h0024, 4'h2, "t4_drop");
    add(0, 4'h3, 0, 1, 16'h0024, 4'h2, "t4_newown");
    add(0, 4'h3, 0, 1, 16'h0024, 4'h1, "t4_after");
    // Lock extends a weight-1 owner.
    add(1, 4'h0, 0, 1, 16'h1111, 4'h0, "t5_reset");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h1, "t5_pre");
    for (int i = 0; i < 5; i++) add(0, 4'hF, 1, 1, 16'h1111, 4'h2, "t5_lock");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h2, "t5_release");
    add(0, 4'hF, 0, 1, 16'h1111, 4'h4, "t5_next");
    // Zero weight counts as one; reset in the middle of a burst.
    add(1, 4'h0, 0, 1, 16'h0500, 4'h0, "t6_reset");
    add(0, 4'hF, 0, 1, 16'h0500, 4'h1, "t6_w0");
    add(0, 4'hF, 0, 1, 16'h0500, 4'h2, "t6_w1");
    add(0, 4'hF, 0, 1, 16'h0500, 4'h4, "t6_b0");
    add(0, 4'hF, 0, 1, 16'h0500, 4'h4, "t6_b1");
    add(1, 4'h0, 0, 1, 16'h0500, 4'h0, "t6_midrst");
    add(0, 4'hF, 0, 1, 16'h0500, 4'h1, "t6_after");

    @(posedge clk); #1;
    foreach (tbl[n]) begin
      rst_n = !tbl[n].rst;
      req   = tbl[n].req;
      lock  = tbl[n].lock;
      ready = tbl[n].ready;
      wt    = tbl[n].wt;
      @(negedge clk);
      check({tbl[n].name, "_gnt"}, 32'(gnt), 32'(tbl[n].exp));
      check({tbl[n].name, "_idx"}, 32'(gnt_idx), 32'(oh_idx(tbl[n].exp)));
      check({tbl[n].name, "_vld"}, 32'(valid), 32'(|tbl[n].exp));
      @(posedge clk); #1;
    end

    // Randomized run against the model, with occasional resets.
    rst_n = 1'b0; req = '0; lock = 1'b0; ready = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int gm;
      logic [N-1:0] exp_g;
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      lock  = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 3) != 0);
      wt    = 16'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      if (!rst_n) m_reset();
      @(negedge clk);
      gm    = m_pick();
      exp_g = (gm < 0) ? '0 : (N'(1) << gm);
      check("rand_gnt", 32'(gnt), 32'(exp_g));
      check("rand_idx", 32'(gnt_idx), (gm < 0) ? 32'd0 : 32'(gm));
      check("rand_vld", 32'(valid), 32'(gm >= 0));
      @(posedge clk);
      if (rst_n) m_edge();
      #1;
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
